// File: rtl/soc_evt_collector.sv
// soc_evt_collector
// Gathers single-cycle event pulses from NB_SRC SoC peripheral sources, keeps a
// saturating pending count per source, and hands event IDs one at a time to the
// cluster event unit over a valid/ready port. Sources are served round-robin.
// A source loses events only after its counter has saturated, and that loss is
// recorded in a sticky overflow flag.
module soc_evt_collector #(
   parameter int NB_SRC      = 4,
   parameter int EVNT_WIDTH  = 8,
   parameter int EVT_ID_BASE = 0,
   parameter int CNT_WIDTH   = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NB_SRC-1:0]     src_evt_i,
   output logic                  evt_valid_o,
   input  logic                  evt_ready_i,
   output logic [EVNT_WIDTH-1:0] evt_data_o,
   output logic [NB_SRC-1:0]     pending_o,
   output logic [NB_SRC-1:0]     overflow_o,
   input  logic [NB_SRC-1:0]     ovf_clr_i
);

   localparam int IDX_W = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_SRC - 1);

   // The output register is either empty or holding an ID for the consumer
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } out_state_e;

   out_state_e state_q, state_d;

   logic [CNT_WIDTH-1:0]  cnt_q [NB_SRC];
   logic [CNT_WIDTH-1:0]  cnt_d [NB_SRC];
   logic [NB_SRC-1:0]     pending;
   logic [NB_SRC-1:0]     ovf_set;
   logic [NB_SRC-1:0]     ovf_q;
   logic [NB_SRC-1:0]     dec;
   logic [IDX_W-1:0]      rr_ptr_q;
   logic [IDX_W-1:0]      winner;
   logic                  found;
   logic                  load_en;
   logic                  grant;
   logic [EVNT_WIDTH-1:0] data_q;

   // Flag every source whose counter holds at least one occurrence
   always_comb begin
      pending = '0;
      for (int i = 0; i < NB_SRC; i++) begin
         pending[i] = (cnt_q[i] != '0);
      end
   end

   // Round-robin search over pending sources, starting at the pointer and wrapping
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int off = 0; off < NB_SRC; off++) begin
         if (!found && pending[(int'(rr_ptr_q) + off) % NB_SRC]) begin
            found  = 1'b1;
            winner = IDX_W'((int'(rr_ptr_q) + off) % NB_SRC);
         end
      end
   end

   // A new ID may be loaded when the output is empty or is being taken this cycle
   always_comb begin
      load_en = (state_q == IDLE) || evt_ready_i;
      grant   = load_en && found;
      dec     = '0;
      if (grant) begin
         dec[winner] = 1'b1;
      end
   end

   // Counter update: pulse adds, grant removes, both together cancel; saturate at max
   always_comb begin
      ovf_set = '0;
      for (int i = 0; i < NB_SRC; i++) begin
         cnt_d[i] = cnt_q[i];
         if (src_evt_i[i] && !dec[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               ovf_set[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end else if (!src_evt_i[i] && dec[i]) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
         end
      end
   end

   // Pending counters register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NB_SRC; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NB_SRC; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Sticky overflow flags; a fresh overflow beats a simultaneous clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ovf_q <= '0;
      end else begin
         ovf_q <= ovf_set | (ovf_q & ~ovf_clr_i);
      end
   end

   // Round-robin pointer moves just past the last granted source
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q <= '0;
      end else if (grant) begin
         rr_ptr_q <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
      end
   end

   // Output-valid state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next output-valid state: fill on grant, empty when taken with nothing left
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (evt_ready_i && !grant) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Event ID register; keeps its last value when the output drains
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else if (grant) begin
         data_q <= EVNT_WIDTH'(EVT_ID_BASE) + EVNT_WIDTH'(winner);
      end
   end

   assign evt_valid_o = (state_q == HOLD);
   assign evt_data_o  = data_q;
   assign pending_o   = pending;
   assign overflow_o  = ovf_q;

endmodule
